// File: rtl/reverse_converter_9_8_7_pkg.sv
// reverse_converter_9_8_7_pkg: moduli, CRT weights, widths and stage types for the (9,8,7) RNS reverse converter
package reverse_converter_9_8_7_pkg;
  localparam int M1 = 9;
  localparam int M2 = 8;
  localparam int M3 = 7;
  localparam int M = M1 * M2 * M3;
  localparam int W1 = 280;
  localparam int W2 = 441;
  localparam int W3 = 288;
  localparam int X1_W = 4;
  localparam int X2_W = 3;
  localparam int X3_W = 3;
  localparam int OUT_W = 9;
  localparam int SUM_W = 13;
  typedef struct packed {
    logic valid;
    logic err;
    logic [SUM_W-1:0] sum;
  } stage1_t;
  function automatic logic legal(input logic [X1_W-1:0] x1, input logic [X3_W-1:0] x3);
    return (x1 < X1_W'(M1)) && (x3 < X3_W'(M3));
  endfunction
  // Max legal sum is 7055, so 13 bits hold it exactly; illegal triples are never summed.
  function automatic logic [SUM_W-1:0] crt_sum(input logic [X1_W-1:0] x1, input logic [X2_W-1:0] x2,
                                               input logic [X3_W-1:0] x3);
    return SUM_W'(W1) * SUM_W'(x1) + SUM_W'(W2) * SUM_W'(x2) + SUM_W'(W3) * SUM_W'(x3);
  endfunction
endpackage

// File: rtl/reverse_converter_9_8_7_if.sv
// reverse_converter_9_8_7_if: residue-triple input and binary result output bundle
interface reverse_converter_9_8_7_if;
  import reverse_converter_9_8_7_pkg::*;
  logic in_valid;
  logic [X1_W-1:0] x1;
  logic [X2_W-1:0] x2;
  logic [X3_W-1:0] x3;
  logic out_valid;
  logic [OUT_W-1:0] out;
  logic out_err;
  modport master(output in_valid, x1, x2, x3, input out_valid, out, out_err);
  modport slave(input in_valid, x1, x2, x3, output out_valid, out, out_err);
endinterface

// File: rtl/reverse_converter_9_8_7_mod504_reduce.sv
// mod504_reduce: exact combinational 13-bit mod 504 by restoring subtraction of 504*16..504*1
module mod504_reduce
  import reverse_converter_9_8_7_pkg::*;
(
  input  logic [SUM_W-1:0] sum,
  output logic [OUT_W-1:0] rem
);
  logic [SUM_W-1:0] r [5];
  assign r[0] = sum;
  for (genvar g = 0; g < 4; g++) begin : g_step
    localparam logic [SUM_W-1:0] D = SUM_W'(M) << (4 - g);
    assign r[g+1] = (r[g] >= D) ? r[g] - D : r[g];
  end
  assign rem = OUT_W'((r[4] >= SUM_W'(M)) ? r[4] - SUM_W'(M) : r[4]);
endmodule

// File: rtl/reverse_converter_9_8_7.sv
// reverse_converter_9_8_7: two-stage CRT reverse converter, residues (9,8,7) to binary 0..503
module reverse_converter_9_8_7
  import reverse_converter_9_8_7_pkg::*;
(
  input logic clk,
  input logic rst_n,
  reverse_converter_9_8_7_if.slave bus
);
  stage1_t s1;
  logic ok;
  logic [OUT_W-1:0] rem;
  assign ok = legal(bus.x1, bus.x3);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1 <= '0;
    else begin
      s1.valid <= bus.in_valid;
      s1.err <= bus.in_valid & ~ok;
      s1.sum <= (bus.in_valid && ok) ? crt_sum(bus.x1, bus.x2, bus.x3) : '0;
    end
  mod504_reduce u_reduce (.sum(s1.sum), .rem(rem));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_err <= 1'b0;
      bus.out <= '0;
    end else begin
      bus.out_valid <= s1.valid;
      bus.out_err <= s1.valid & s1.err;
      bus.out <= (s1.valid && !s1.err) ? rem : '0;
    end
endmodule

// File: tb/tb_reverse_converter_9_8_7.sv
// tb_reverse_converter_9_8_7: vector table, full sweep, illegal, idle and mid-flight reset checks via scoreboard
module tb_reverse_converter_9_8_7;
  import reverse_converter_9_8_7_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  reverse_converter_9_8_7_if bus();
  reverse_converter_9_8_7 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { logic [8:0] out; logic err; int due; } exp_t;
  typedef struct { logic [3:0] x1; logic [2:0] x2; logic [2:0] x3; logic [8:0] out; logic err; } vec_t;
  exp_t sbq[$];
  exp_t e;
  vec_t vecs[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic drive(input logic v, input logic [3:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [8:0] eo, input logic ee);
    @(negedge clk);
    bus.in_valid = v;
    bus.x1 = a;
    bus.x2 = b;
    bus.x3 = c;
    if (v) sbq.push_back('{eo, ee, cyc + 2});
  endtask
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (bus.out_valid) begin
      if (sbq.size() == 0) check("spurious out_valid", bus.out_valid, 0);
      else begin
        e = sbq.pop_front();
        check("out", bus.out, e.out);
        check("out_err", bus.out_err, e.err);
        check("latency", cyc, e.due);
      end
    end else begin
      check("idle out", bus.out, 0);
      check("idle out_err", bus.out_err, 0);
      if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        check("missing out_valid", bus.out_valid, 1);
        void'(sbq.pop_front());
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{4'd0,  3'd0, 3'd0, 9'd0,   1'b0};
    vecs[1]  = '{4'd1,  3'd1, 3'd1, 9'd1,   1'b0};
    vecs[2]  = '{4'd8,  3'd7, 3'd6, 9'd503, 1'b0};
    vecs[3]  = '{4'd3,  3'd7, 3'd3, 9'd255, 1'b0};
    vecs[4]  = '{4'd1,  3'd4, 3'd2, 9'd100, 1'b0};
    vecs[5]  = '{4'd8,  3'd0, 3'd1, 9'd8,   1'b0};
    vecs[6]  = '{4'd0,  3'd0, 3'd1, 9'd288, 1'b0};
    vecs[7]  = '{4'd1,  3'd0, 3'd0, 9'd280, 1'b0};
    vecs[8]  = '{4'd9,  3'd0, 3'd0, 9'd0,   1'b1};
    vecs[9]  = '{4'd0,  3'd0, 3'd7, 9'd0,   1'b1};
    vecs[10] = '{4'd15, 3'd7, 3'd7, 9'd0,   1'b1};
    vecs[11] = '{4'd12, 3'd3, 3'd2, 9'd0,   1'b1};
    bus.in_valid = 1'b0;
    bus.x1 = '0;
    bus.x2 = '0;
    bus.x3 = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out", bus.out, 0);
    check("reset out_err", bus.out_err, 0);
    rst_n = 1'b1;
    foreach (vecs[i]) drive(1'b1, vecs[i].x1, vecs[i].x2, vecs[i].x3, vecs[i].out, vecs[i].err);
    drive(1'b1, 4'd3, 3'd7, 3'd3, 9'd255, 1'b0);
    repeat (3) drive(1'b0, 4'd0, 3'd0, 3'd0, 9'd0, 1'b0);
    for (int n = 0; n < 504; n++) drive(1'b1, 4'(n % 9), 3'(n % 8), 3'(n % 7), 9'(n), 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 4'($urandom), 3'($urandom), 3'($urandom), 9'd0, 1'b0);
    // Two conversions in flight: first at the output, second in stage 1, then async reset mid-cycle.
    drive(1'b1, 4'd1, 3'd4, 3'd2, 9'd100, 1'b0);
    drive(1'b1, 4'd8, 3'd7, 3'd6, 9'd503, 1'b0);
    @(posedge clk);
    #2;
    check("pre-reset out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("async reset out_valid", bus.out_valid, 0);
    check("async reset out", bus.out, 0);
    check("async reset out_err", bus.out_err, 0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) drive(1'b0, 4'd5, 3'd5, 3'd5, 9'd0, 1'b0);
    drive(1'b1, 4'd8, 3'd7, 3'd6, 9'd503, 1'b0);
    drive(1'b1, 4'd9, 3'd2, 3'd7, 9'd0, 1'b1);
    for (int i = 0; i < 10 && sbq.size() != 0; i++) drive(1'b0, 4'd0, 3'd0, 3'd0, 9'd0, 1'b0);
    check("scoreboard drained", sbq.size(), 0);
    repeat (3) drive(1'b0, 4'd0, 3'd0, 3'd0, 9'd0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
